gate_response_checker: RTL and testbench

//  Response-side counterpart to the gate stimulus drivers. It observes input/output triples of a
//  2-input gate under test (a, b, y), one per valid/ready handshake.

---
 rtl/gate_chk_pkg.sv | 24 ++
 rtl/gate_tt_lookup.sv | 14 +
 rtl/gate_response_checker.sv | 129 ++++++++++++
 tb/tb_gate_response_checker.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/gate_chk_pkg.sv
// Shared types and constants for the on-chip 2-input gate response checker.
// Truth tables are indexed by {a,b}: bit 0 is the expected output for a=0,b=0.
package gate_chk_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        DONE
    } gate_chk_state_t;

    localparam logic [3:0] NAND_TT = 4'b0111;
    localparam logic [3:0] AND_TT  = 4'b1000;
    localparam logic [3:0] OR_TT   = 4'b1110;
    localparam logic [3:0] NOR_TT  = 4'b0001;
    localparam logic [3:0] XOR_TT  = 4'b0110;

    localparam logic [3:0] FULL_COVERAGE = 4'b1111;

    // One-hot coverage bit for a given {a,b} input combination.
    function automatic logic [3:0] combo_bit(input logic [1:0] combo);
        return 4'b0001 << combo;
    endfunction

endpackage

// File: rtl/gate_tt_lookup.sv
// Combinational expected-output lookup: selects the truth-table entry for inputs (a, b).
module gate_tt_lookup
(
    input  logic [3:0] tt,
    input  logic       a,
    input  logic       b,
    output logic       exp_y
);

    always_comb begin
        exp_y = tt[{a, b}];
    end

endmodule

// File: rtl/gate_response_checker.sv
// Checks observed (a, b, y) triples of a 2-input gate against TRUTH_TABLE until all four
// input combinations are covered. Optional first-failure capture: GATE_CHK_FIRST_FAIL_EN.
module gate_response_checker
    import gate_chk_pkg::*;
#(
    parameter logic [3:0] TRUTH_TABLE = NAND_TT,
    parameter int         ERR_W       = 8
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sample_valid,
    output logic             sample_ready,
    input  logic             in_a,
    input  logic             in_b,
    input  logic             dut_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [3:0]       coverage
`ifdef GATE_CHK_FIRST_FAIL_EN
    ,
    output logic             fail_seen,
    output logic [2:0]       fail_vec
`endif
);

    gate_chk_state_t state;
    gate_chk_state_t next_state;

    logic             accept;
    logic             exp_y;
    logic             mismatch;
    logic             enter_check;
    logic [1:0]       combo;
    logic [3:0]       cov_next;
    logic [ERR_W-1:0] err_next;

    assign combo    = {in_a, in_b};
    assign accept   = sample_valid & sample_ready;
    assign mismatch = accept & (dut_out != exp_y);
    assign cov_next = coverage | combo_bit(combo);

    gate_tt_lookup u_lookup (
        .tt    (TRUTH_TABLE),
        .a     (in_a),
        .b     (in_b),
        .exp_y (exp_y)
    );

    // The counter sticks at all-ones so a long faulty run never wraps back to "passing".
    always_comb begin
        err_next = err_count;
        if (mismatch && !(&err_count)) begin
            err_next = err_count + ERR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = CHECK;
            CHECK:   if (accept && (cov_next == FULL_COVERAGE)) next_state = DONE;
            DONE:    if (start) next_state = CHECK;
            default: next_state = IDLE;
        endcase
    end

    assign enter_check = (state != CHECK) && (next_state == CHECK);

    always_comb begin
        sample_ready = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        case (state)
            CHECK: begin
                sample_ready = 1'b1;
                busy         = 1'b1;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // pass is only resolved on the completing accept, so it includes that final sample.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_count <= '0;
            coverage  <= '0;
            pass      <= 1'b0;
        end else if (enter_check) begin
            err_count <= '0;
            coverage  <= '0;
            pass      <= 1'b0;
        end else if (accept) begin
            err_count <= err_next;
            coverage  <= cov_next;
            if (cov_next == FULL_COVERAGE) begin
                pass <= (err_next == '0);
            end
        end
    end

`ifdef GATE_CHK_FIRST_FAIL_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fail_seen <= 1'b0;
            fail_vec  <= '0;
        end else if (enter_check) begin
            fail_seen <= 1'b0;
            fail_vec  <= '0;
        end else if (mismatch && !fail_seen) begin
            fail_seen <= 1'b1;
            fail_vec  <= {in_a, in_b, dut_out};
        end
    end
`endif

endmodule

// File: tb/tb_gate_response_checker.sv
// Scoreboard bench for gate_response_checker (NAND table, ERR_W=8); directed vectors with
// hand-computed expectations, checked by an independent monitor on every accepted triple.
module tb_gate_response_checker;
    import gate_chk_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       sample_valid;
    logic       sample_ready;
    logic       in_a;
    logic       in_b;
    logic       dut_out;
    logic       busy;
    logic       done;
    logic       pass;
    logic [7:0] err_count;
    logic [3:0] coverage;
`ifdef GATE_CHK_FIRST_FAIL_EN
    logic       fail_seen;
    logic [2:0] fail_vec;
`endif

    int numChecks = 0;
    int numFails  = 0;

    // Packed expectation: {ready, busy, done, pass, coverage[3:0], err_count[7:0]}
    logic [15:0] expQ[$];

    gate_response_checker #(
        .TRUTH_TABLE (NAND_TT),
        .ERR_W       (8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .in_a         (in_a),
        .in_b         (in_b),
        .dut_out      (dut_out),
        .busy         (busy),
        .done         (done),
        .pass         (pass),
        .err_count    (err_count),
        .coverage     (coverage)
`ifdef GATE_CHK_FIRST_FAIL_EN
        ,
        .fail_seen    (fail_seen),
        .fail_vec     (fail_vec)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] mkExp(input logic rdy, input logic bsy, input logic dn,
                                          input logic ps, input logic [3:0] cov,
                                          input logic [7:0] err);
        return {rdy, bsy, dn, ps, cov, err};
    endfunction

    function automatic logic [15:0] observed();
        return {sample_ready, busy, done, pass, coverage, err_count};
    endfunction

    // Monitor: whenever a triple is accepted, compare next-cycle outputs to the queue head.
    always @(posedge clk) begin
        if (rst_n === 1'b1 && sample_valid === 1'b1 && sample_ready === 1'b1) begin
            #1;
            numChecks++;
            if (expQ.size() == 0) begin
                numFails++;
                $display("[TB] FAIL accept_unexpected: got %h, required no accept", observed());
            end else begin
                logic [15:0] e;
                e = expQ.pop_front();
                if (observed() !== e) begin
                    numFails++;
                    $display("[TB] FAIL accept_result: got {rdy,busy,done,pass,cov,err}=%b_%b_%b_%b_%b_%0d, required %b_%b_%b_%b_%b_%0d",
                             sample_ready, busy, done, pass, coverage, err_count,
                             e[15], e[14], e[13], e[12], e[11:8], e[7:0]);
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [15:0] e);
        numChecks++;
        if (observed() !== e) begin
            numFails++;
            $display("[TB] FAIL %s: got {rdy,busy,done,pass,cov,err}=%b_%b_%b_%b_%b_%0d, required %b_%b_%b_%b_%b_%0d",
                     name, sample_ready, busy, done, pass, coverage, err_count,
                     e[15], e[14], e[13], e[12], e[11:8], e[7:0]);
        end
    endtask

`ifdef GATE_CHK_FIRST_FAIL_EN
    task automatic checkFirstFail(input string name, input logic seen, input logic [2:0] vec);
        numChecks++;
        if (fail_seen !== seen || fail_vec !== vec) begin
            numFails++;
            $display("[TB] FAIL %s: got fail_seen=%b fail_vec=%b, required fail_seen=%b fail_vec=%b",
                     name, fail_seen, fail_vec, seen, vec);
        end
    endtask
`endif

    // Present one triple and push the hand-computed response; waits (bounded) for acceptance.
    task automatic applyStimulus(input logic a, input logic b, input logic y,
                                 input logic [3:0] cov, input logic [7:0] err,
                                 input logic dn, input logic ps);
        bit accepted;
        @(negedge clk);
        in_a         = a;
        in_b         = b;
        dut_out      = y;
        sample_valid = 1'b1;
        expQ.push_back(mkExp(!dn, !dn, dn, ps, cov, err));
        accepted = 1'b0;
        for (int i = 0; i < 8 && !accepted; i++) begin
            @(posedge clk);
            if (sample_ready === 1'b1) accepted = 1'b1;
        end
        if (!accepted) begin
            numChecks++;
            numFails++;
            void'(expQ.pop_back());
            $display("[TB] FAIL accept_timeout: got sample_ready=%b, required 1 within 8 cycles", sample_ready);
        end
    endtask

    task automatic idleBus();
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    task automatic startRun(input string name);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput(name, mkExp(1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 8'd0));
    endtask

    // Drive valid for two cycles where the checker must not accept; outputs must not move.
    task automatic pulseUnready(input string name, input logic [15:0] e);
        @(negedge clk);
        in_a         = 1'b1;
        in_b         = 1'b1;
        dut_out      = 1'b1;
        sample_valid = 1'b1;
        @(negedge clk);
        @(negedge clk);
        sample_valid = 1'b0;
        checkOutput(name, e);
    endtask

    task automatic waitDrain();
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n        = 1'b0;
        start        = 1'b0;
        sample_valid = 1'b0;
        in_a         = 1'b0;
        in_b         = 1'b0;
        dut_out      = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_state", 16'h0000);
        rst_n = 1'b1;

        pulseUnready("valid_in_idle", 16'h0000);

        // Run 1: all-correct NAND sweep
        startRun("start_from_idle");
        applyStimulus(0, 0, 1, 4'b0001, 8'd0, 0, 0);
        applyStimulus(1, 0, 1, 4'b0101, 8'd0, 0, 0);
        applyStimulus(0, 1, 1, 4'b0111, 8'd0, 0, 0);
        applyStimulus(1, 1, 0, 4'b1111, 8'd0, 1, 1);
        idleBus();
        checkOutput("run1_done_hold", mkExp(0, 0, 1, 1, 4'b1111, 8'd0));
        pulseUnready("valid_in_done", mkExp(0, 0, 1, 1, 4'b1111, 8'd0));

        // Run 2: restart from DONE, last triple wrong
        startRun("start_from_done");
`ifdef GATE_CHK_FIRST_FAIL_EN
        checkFirstFail("ff_cleared_run2", 1'b0, 3'b000);
`endif
        applyStimulus(0, 0, 1, 4'b0001, 8'd0, 0, 0);
        applyStimulus(1, 0, 1, 4'b0101, 8'd0, 0, 0);
        applyStimulus(0, 1, 1, 4'b0111, 8'd0, 0, 0);
        applyStimulus(1, 1, 1, 4'b1111, 8'd1, 1, 0);
        idleBus();
        checkOutput("run2_done_fail", mkExp(0, 0, 1, 0, 4'b1111, 8'd1));
`ifdef GATE_CHK_FIRST_FAIL_EN
        checkFirstFail("ff_run2", 1'b1, 3'b111);
`endif

        // Run 3: repeated combination does not advance coverage
        startRun("start_run3");
        applyStimulus(0, 0, 1, 4'b0001, 8'd0, 0, 0);
        applyStimulus(0, 0, 1, 4'b0001, 8'd0, 0, 0);
        applyStimulus(0, 0, 1, 4'b0001, 8'd0, 0, 0);
        applyStimulus(1, 0, 1, 4'b0101, 8'd0, 0, 0);
        applyStimulus(0, 1, 1, 4'b0111, 8'd0, 0, 0);
        applyStimulus(1, 1, 0, 4'b1111, 8'd0, 1, 1);
        idleBus();

        // Reset and start together from DONE: reset wins
        @(negedge clk);
        start = 1'b1;
        rst_n = 1'b0;
        @(negedge clk);
        start = 1'b0;
        rst_n = 1'b1;
        checkOutput("reset_beats_start", 16'h0000);

        // Run 4: start ignored mid-run, then mid-run reset abandons it
        startRun("start_run4");
        applyStimulus(0, 0, 1, 4'b0001, 8'd0, 0, 0);
        applyStimulus(1, 0, 1, 4'b0101, 8'd0, 0, 0);
        idleBus();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("start_ignored_in_check", mkExp(1, 1, 0, 0, 4'b0101, 8'd0));
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("midrun_reset", 16'h0000);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("idle_after_reset", 16'h0000);

        // Run 5: 300 wrong (0,0,0) triples saturate the counter at 255
        startRun("start_run5");
        for (int i = 0; i < 300; i++) begin
            applyStimulus(0, 0, 0, 4'b0001, (i + 1 > 255) ? 8'd255 : 8'(i + 1), 0, 0);
        end
        applyStimulus(1, 0, 1, 4'b0101, 8'd255, 0, 0);
        applyStimulus(0, 1, 1, 4'b0111, 8'd255, 0, 0);
        applyStimulus(1, 1, 0, 4'b1111, 8'd255, 1, 0);
        idleBus();
        checkOutput("run5_saturated", mkExp(0, 0, 1, 0, 4'b1111, 8'd255));
`ifdef GATE_CHK_FIRST_FAIL_EN
        checkFirstFail("ff_run5", 1'b1, 3'b000);
`endif

        // Restart from DONE after a failing run clears everything
        startRun("restart_clears");
`ifdef GATE_CHK_FIRST_FAIL_EN
        checkFirstFail("ff_cleared_restart", 1'b0, 3'b000);
`endif

        waitDrain();
        numChecks++;
        if (expQ.size() != 0) begin
            numFails++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending, required 0", expQ.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
        $finish;
    end

endmodule
